// File: rtl/jtkicker_colmix.sv
// jtkicker_colmix
//   Colour mixer for the scroll and object layers. It picks one pixel per
//   pxl_cen tick by transparency priority, looks up RGB in three
//   downloadable 256x4 PROMs, and gates the result with delayed blanking.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   pxl_cen             pixel clock enable; every pipeline register holds when low
//   pal_sel, gfx_en     palette bank, debug layer enables (bit0 scroll, bit1 object)
//   scr_pxl, obj_pxl    layer pixels (object 0 = transparent)
//   LHBL, LVBL          blanking inputs, active low
//   prog_addr/data/en   PROM download port ([9:8] selects R/G/B, 3 is ignored)
//   red, green, blue    colour outputs, RGB_DW bits each
//   LHBL_dly, LVBL_dly  blanking delayed by BLANK_DLY pxl_cen ticks
module jtkicker_colmix #(
  parameter int unsigned BLANK_DLY = 2,
  parameter int unsigned RGB_DW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic [2:0]        pal_sel,
  input  logic [1:0]        gfx_en,
  input  logic [3:0]        scr_pxl,
  input  logic [3:0]        obj_pxl,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic [9:0]        prog_addr,
  input  logic [3:0]        prog_data,
  input  logic              prog_en,
  output logic [RGB_DW-1:0] red,
  output logic [RGB_DW-1:0] green,
  output logic [RGB_DW-1:0] blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly
);

  logic [3:0] prom_r [256];
  logic [3:0] prom_g [256];
  logic [3:0] prom_b [256];

  logic [7:0]           idx_q, idx_d;
  logic [BLANK_DLY-1:0] hbl_q, hbl_d;
  logic [BLANK_DLY-1:0] vbl_q, vbl_d;
  logic [RGB_DW-1:0]    red_q, red_d;
  logic [RGB_DW-1:0]    green_q, green_d;
  logic [RGB_DW-1:0]    blue_q, blue_d;

  logic       obj_vis;
  logic [3:0] scr_eff;
  logic       vis;

  // PROM data is MSB-aligned; extra LSBs repeat the 4-bit value from its MSB.
  function automatic logic [RGB_DW-1:0] expand(input logic [3:0] d);
    logic [RGB_DW-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < RGB_DW; i++)
      res[RGB_DW-1-i] = d[3-(i%4)];
    return res;
  endfunction

  // Download port is independent of pxl_cen; a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (prog_en) begin
      case (prog_addr[9:8])
        2'd0:    prom_r[prog_addr[7:0]] <= prog_data;
        2'd1:    prom_g[prog_addr[7:0]] <= prog_data;
        2'd2:    prom_b[prog_addr[7:0]] <= prog_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    obj_vis = gfx_en[1] & (obj_pxl != 4'd0);
    scr_eff = gfx_en[0] ? scr_pxl : 4'd0;
    idx_d   = {pal_sel, obj_vis, obj_vis ? obj_pxl : scr_eff};

    hbl_d = {hbl_q[BLANK_DLY-2:0], LHBL};
    vbl_d = {vbl_q[BLANK_DLY-2:0], LVBL};

    // Tap 0 sampled at this edge becomes tap 1 after it: the colour register
    // and a 2-deep blank chain therefore switch on the same tick, whatever
    // BLANK_DLY is.
    vis     = hbl_q[0] & vbl_q[0];
    red_d   = vis ? expand(prom_r[idx_q]) : '0;
    green_d = vis ? expand(prom_g[idx_q]) : '0;
    blue_d  = vis ? expand(prom_b[idx_q]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      hbl_q   <= '0;
      vbl_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pxl_cen) begin
      idx_q   <= idx_d;
      hbl_q   <= hbl_d;
      vbl_q   <= vbl_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = hbl_q[BLANK_DLY-1];
  assign LVBL_dly = vbl_q[BLANK_DLY-1];

endmodule

// File: tb/tb_jtkicker_colmix.sv
module tb_jtkicker_colmix;

  logic       clk = 1'b0;
  logic       rst_n, pxl_cen, LHBL, LVBL, prog_en;
  logic [2:0] pal_sel;
  logic [1:0] gfx_en;
  logic [3:0] scr_pxl, obj_pxl, prog_data;
  logic [9:0] prog_addr;

  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;
  logic [5:0] red6, green6, blue6;
  logic       LHBL_dly4, LVBL_dly4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtkicker_colmix u_dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pal_sel(pal_sel),
    .gfx_en(gfx_en), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl),
    .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_en(prog_en), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  jtkicker_colmix #(.BLANK_DLY(4), .RGB_DW(6)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pal_sel(pal_sel),
    .gfx_en(gfx_en), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl),
    .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_en(prog_en), .red(red6), .green(green6), .blue(blue6),
    .LHBL_dly(LHBL_dly4), .LVBL_dly(LVBL_dly4)
  );

  task automatic tick();
    @(negedge clk) pxl_cen = 1'b1;
    @(negedge clk) pxl_cen = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic prom_wr(input logic [9:0] a, input logic [3:0] d);
    @(negedge clk);
    prog_addr = a; prog_data = d; prog_en = 1'b1;
    @(negedge clk) prog_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pxl_cen = 1'b0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    pal_sel = 3'd0; gfx_en = 2'b11; obj_pxl = 4'd0; scr_pxl = 4'd3;
    LHBL = 1'b1; LVBL = 1'b1;
    prom_wr(10'h003, 4'h5);
    prom_wr(10'h015, 4'hA);
    prom_wr(10'h000, 4'hC);
    repeat (3) tick();
    n_cmp++; if (red !== 4'h0)   begin n_err++; $display("FAIL rst_red got=%h exp=%h", red, 4'h0); end
    n_cmp++; if (green !== 4'h0) begin n_err++; $display("FAIL rst_green got=%h exp=%h", green, 4'h0); end
    n_cmp++; if (blue !== 4'h0)  begin n_err++; $display("FAIL rst_blue got=%h exp=%h", blue, 4'h0); end
    n_cmp++; if (LHBL_dly !== 1'b0) begin n_err++; $display("FAIL rst_lhbl got=%b exp=0", LHBL_dly); end
    n_cmp++; if (LVBL_dly !== 1'b0) begin n_err++; $display("FAIL rst_lvbl got=%b exp=0", LVBL_dly); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_cmp++; if (red !== 4'h0) begin n_err++; $display("FAIL rel_t1_red got=%h exp=%h", red, 4'h0); end
    n_cmp++; if (LHBL_dly !== 1'b0) begin n_err++; $display("FAIL rel_t1_lhbl got=%b exp=0", LHBL_dly); end
    tick();
    n_cmp++; if (red !== 4'h5) begin n_err++; $display("FAIL rel_t2_red got=%h exp=%h", red, 4'h5); end
    n_cmp++; if (LHBL_dly !== 1'b1) begin n_err++; $display("FAIL rel_t2_lhbl got=%b exp=1", LHBL_dly); end
  endtask

  task automatic test_priority();
    obj_pxl = 4'd5; scr_pxl = 4'd3;
    tick();
    n_cmp++; if (red !== 4'h5) begin n_err++; $display("FAIL prio_lat got=%h exp=%h", red, 4'h5); end
    tick();
    n_cmp++; if (red !== 4'hA) begin n_err++; $display("FAIL prio_obj got=%h exp=%h", red, 4'hA); end
    obj_pxl = 4'd0;
    tick(); tick();
    n_cmp++; if (red !== 4'h5) begin n_err++; $display("FAIL prio_scr got=%h exp=%h", red, 4'h5); end
  endtask

  task automatic test_enables();
    gfx_en = 2'b01; obj_pxl = 4'd5; scr_pxl = 4'd3;
    tick(); tick();
    n_cmp++; if (red !== 4'h5) begin n_err++; $display("FAIL en_objoff got=%h exp=%h", red, 4'h5); end
    gfx_en = 2'b00;
    tick(); tick();
    n_cmp++; if (red !== 4'hC) begin n_err++; $display("FAIL en_alloff got=%h exp=%h", red, 4'hC); end
    gfx_en = 2'b10;
    tick(); tick();
    n_cmp++; if (red !== 4'hA) begin n_err++; $display("FAIL en_scroff got=%h exp=%h", red, 4'hA); end
  endtask

  task automatic test_palette();
    prom_wr(10'h0A7, 4'h1);
    prom_wr(10'h1A7, 4'h2);
    prom_wr(10'h2A7, 4'h3);
    gfx_en = 2'b11; pal_sel = 3'b101; obj_pxl = 4'd0; scr_pxl = 4'h7;
    tick(); tick();
    n_cmp++; if (red !== 4'h1)   begin n_err++; $display("FAIL pal_red got=%h exp=%h", red, 4'h1); end
    n_cmp++; if (green !== 4'h2) begin n_err++; $display("FAIL pal_green got=%h exp=%h", green, 4'h2); end
    n_cmp++; if (blue !== 4'h3)  begin n_err++; $display("FAIL pal_blue got=%h exp=%h", blue, 4'h3); end
    n_cmp++; if (red6 !== 6'h04)   begin n_err++; $display("FAIL pal_red6 got=%h exp=%h", red6, 6'h04); end
    n_cmp++; if (green6 !== 6'h08) begin n_err++; $display("FAIL pal_green6 got=%h exp=%h", green6, 6'h08); end
    n_cmp++; if (blue6 !== 6'h0C)  begin n_err++; $display("FAIL pal_blue6 got=%h exp=%h", blue6, 6'h0C); end
    prom_wr(10'h3A7, 4'hF);
    tick(); tick();
    n_cmp++; if ({red, green, blue} !== 12'h123) begin
      n_err++; $display("FAIL pal_sel3 got=%h exp=%h", {red, green, blue}, 12'h123); end
    // write and read of A7 land on the same edge: old value first, then new
    @(negedge clk);
    prog_addr = 10'h0A7; prog_data = 4'h9; prog_en = 1'b1; pxl_cen = 1'b1;
    @(negedge clk) begin prog_en = 1'b0; pxl_cen = 1'b0; end
    n_cmp++; if (red !== 4'h1) begin n_err++; $display("FAIL rw_old got=%h exp=%h", red, 4'h1); end
    tick();
    n_cmp++; if (red !== 4'h9) begin n_err++; $display("FAIL rw_new got=%h exp=%h", red, 4'h9); end
    prom_wr(10'h0A7, 4'h1);
    tick();
  endtask

  task automatic test_blank();
    logic exp_c, exp_d4;
    LHBL = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      LHBL = 1'b1;
      exp_c  = (k != 1);
      exp_d4 = (k != 3);
      n_cmp++; if (red !== (exp_c ? 4'h1 : 4'h0)) begin
        n_err++; $display("FAIL blank_red k=%0d got=%h exp=%h", k, red, exp_c ? 4'h1 : 4'h0); end
      n_cmp++; if (red6 !== (exp_c ? 6'h04 : 6'h00)) begin
        n_err++; $display("FAIL blank_red6 k=%0d got=%h exp=%h", k, red6, exp_c ? 6'h04 : 6'h00); end
      n_cmp++; if (LHBL_dly !== exp_c) begin
        n_err++; $display("FAIL blank_dly2 k=%0d got=%b exp=%b", k, LHBL_dly, exp_c); end
      n_cmp++; if (LHBL_dly4 !== exp_d4) begin
        n_err++; $display("FAIL blank_dly4 k=%0d got=%b exp=%b", k, LHBL_dly4, exp_d4); end
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obj_pxl = 4'(c); pal_sel = 3'(c); LHBL = c[0]; LVBL = c[1];
      if (c % 5 == 4) begin
        n_cmp++; if ({red, green, blue} !== 12'h123) begin
          n_err++; $display("FAIL hold_rgb c=%0d got=%h exp=%h", c, {red, green, blue}, 12'h123); end
        n_cmp++; if ({LHBL_dly, LVBL_dly, LHBL_dly4, LVBL_dly4} !== 4'b1111) begin
          n_err++; $display("FAIL hold_blank c=%0d got=%b exp=1111", c,
                            {LHBL_dly, LVBL_dly, LHBL_dly4, LVBL_dly4}); end
      end
    end
    obj_pxl = 4'd0; pal_sel = 3'b101; LHBL = 1'b1; LVBL = 1'b1;
  endtask

  task automatic test_midreset();
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_cmp++; if ({red, green, blue} !== 12'h000) begin
      n_err++; $display("FAIL mid_rst_rgb got=%h exp=%h", {red, green, blue}, 12'h000); end
    n_cmp++; if (LVBL_dly !== 1'b0) begin n_err++; $display("FAIL mid_rst_lvbl got=%b exp=0", LVBL_dly); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_cmp++; if (red !== 4'h0) begin n_err++; $display("FAIL mid_t1 got=%h exp=%h", red, 4'h0); end
    tick();
    n_cmp++; if ({red, green, blue} !== 12'h123) begin
      n_err++; $display("FAIL mid_t2 got=%h exp=%h", {red, green, blue}, 12'h123); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_enables();
    test_palette();
    test_blank();
    test_hold();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtkicker_colmix.md
Name: jtkicker_colmix

Overview:
Colour mixer downstream of the scroll tile layer and the object layer. Each pixel it picks either the scroll or the object 4-bit pixel by transparency priority. It then builds an 8-bit colour index with the palette bank and looks it up in three downloadable 256x4 RGB PROMs. It delays the blanking signals to stay aligned with the colour output and forces black during blanking.

Parameters:
BLANK_DLY, 2, pxl_cen ticks of LHBL/LVBL delay (legal 2..7); 2 matches the fixed colour pipeline.
RGB_DW, 4, width of each colour output; PROM data is always 4 bits and is MSB-aligned, with LSBs replicated from the MSBs when RGB_DW>4.

Ports:
clk  in  1  48 MHz system clock; only clock.
rst_n  in  1  asynchronous, active-low reset.
pxl_cen  in  1  pixel clock enable (6 MHz rate, one clk wide).
pal_sel  in  3  palette bank, sampled together with the pixel.
gfx_en  in  2  debug layer enables: bit0 = scroll, bit1 = object; 0 forces that layer transparent.
scr_pxl  in  4  scroll layer pixel (palette PROM output of the tile layer).
obj_pxl  in  4  object layer pixel; 0 is transparent.
LHBL  in  1  horizontal blank, active low.
LVBL  in  1  vertical blank, active low.
prog_addr  in  10  download address: [9:8] PROM select (0 = red, 1 = green, 2 = blue, 3 = ignored), [7:0] entry.
prog_data  in  4  download data.
prog_en  in  1  download write strobe, one clk per write.
red  out  RGB_DW  colour output.
green  out  RGB_DW  colour output.
blue  out  RGB_DW  colour output.
LHBL_dly  out  1  LHBL delayed by BLANK_DLY pxl_cen ticks.
LVBL_dly  out  1  LVBL delayed by BLANK_DLY pxl_cen ticks.

Behaviour:
- Reset (rst_n low, asynchronous): red, green and blue = 0. LHBL_dly and LVBL_dly = 0. Pipeline registers and blank shift registers = 0. PROM contents are not cleared.
- All pipeline activity advances only on clk edges where pxl_cen=1. With pxl_cen=0 every register holds.

Stage 1 (first pxl_cen tick):
- obj_vis = gfx_en[1] and obj_pxl != 0.
- scr_eff = scr_pxl when gfx_en[0]=1, else 0.
- idx <= {pal_sel, obj_vis, obj_vis ? obj_pxl : scr_eff}, 8 bits.
- When both layers are transparent, idx = {pal_sel, 1'b0, 4'h0}, i.e. scroll entry 0. This is not forced black.

Stage 2 (second pxl_cen tick):
- PROM read at idx.
- red/green/blue <= PROM data when both blanks are high at the delayed point, else 0.
- Blank gating uses the blank values delayed by 2 ticks (pipeline-aligned tap), even when BLANK_DLY>2.
- Total pixel latency: exactly 2 pxl_cen ticks from input to colour output.

Blanking:
- Independent shift registers, BLANK_DLY deep, clocked on pxl_cen.
- LHBL_dly and LVBL_dly are the last taps.

PROM download:
- Write on any clk with prog_en=1, independent of pxl_cen.
- prog_addr[9:8]=3 is ignored.
- A write and a read of the same entry in the same cycle returns the old data; the new value is visible on the next read.
- Downloads normally happen during reset/blank; no arbitration is needed.

Boundary cases:
- Mid-line reset: outputs go to 0 immediately. The first valid colour appears 2 pxl_cen ticks after rst_n rises.
- pal_sel change mid-line takes effect on the pixel sampled in the same tick; no extra delay.

Test Plan:
- Reset: hold rst_n=0 for 10 clk while pxl_cen toggles -> red/green/blue=0, LHBL_dly=LVBL_dly=0. Release rst_n -> outputs unchanged until 2 pxl_cen ticks later.
- Priority: load red PROM entry 8'h15 = 4'hA and entry 8'h03 = 4'h5. With pal_sel=0, obj_pxl=5, scr_pxl=3 and blanks high -> red=4'hA after 2 pxl_cen. With obj_pxl=0 -> red=4'h5.
- Debug enables: gfx_en=2'b01, obj_pxl=5, scr_pxl=3 -> scroll wins (red=4'h5). gfx_en=2'b00 -> index {0,0,0} = entry 0.
- Palette bank: pal_sel=3'b101, scr_pxl=4'h7 -> read entry 8'hA7. Write a distinct value per R/G/B there; each output shows its own PROM value. Writes with prog_addr[9:8]=3 leave all PROMs unchanged.
- Blanking: drop LHBL for 1 pxl_cen tick during a constant non-zero colour -> exactly one output pixel is 0, 2 ticks later. LHBL_dly falls 2 ticks after LHBL. With BLANK_DLY=4, LHBL_dly falls 4 ticks after LHBL.
- Hold: pxl_cen held low for 20 clk with changing inputs -> outputs and delayed blanks remain constant.
